// File: rtl/lgn_image_loader_if.sv
// Byte-in / image-out handshake bundle for lgn_image_loader.
// slave: the loader; master: the byte producer and image consumer.
interface lgn_image_loader_if #(
    parameter int unsigned INPUTS = 256
) ();
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              in_start;
    logic              mode;
    logic [INPUTS-1:0] out_image;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        drop_count;

    modport slave (
        input  in_data, in_valid, in_start, mode, out_ready,
        output in_ready, out_image, out_valid, drop_count
    );

    modport master (
        output in_data, in_valid, in_start, mode, out_ready,
        input  in_ready, out_image, out_valid, drop_count
    );
endinterface

// File: rtl/lgn_image_loader.sv
// Framed, double-buffered byte-to-image loader in front of the gate network.
// Define LGN_LOADER_GRAYSCALE_EN to compile in 1-pixel-per-byte thresholded mode.
module lgn_image_loader #(
    parameter int unsigned INPUTS    = 256,
    parameter logic [7:0]  THRESHOLD = 8'd128
) (
    input logic              clk,
    input logic              rst_n,
    lgn_image_loader_if.slave bus
);

    typedef enum logic {
        LOAD,
        FULL
    } state_e;

    localparam logic [8:0] PACKED_LEN = 9'(INPUTS / 8);

    state_e            state_q;
    logic [INPUTS-1:0] s_q;
    logic [INPUTS-1:0] o_q;
    logic              ov_q;
    logic [8:0]        cnt_q;
    logic [7:0]        drop_q;

    logic              in_ready;
    logic              accept;
    logic              first;
    logic              mode_eff;
    logic              o_free;
    logic              xfer;
    logic              complete;
    logic [8:0]        frame_len;
    logic [8:0]        cnt_d;
    logic [INPUTS-1:0] s_d;
    logic [INPUTS+7:0] pcat;

    assign in_ready = (state_q == LOAD);
    assign accept   = bus.in_valid && in_ready;
    assign first    = (cnt_q == '0) || bus.in_start;
    assign o_free   = !ov_q || bus.out_ready;
    assign xfer     = ov_q && bus.out_ready;
    assign pcat     = {s_q, bus.in_data};

`ifdef LGN_LOADER_GRAYSCALE_EN
    localparam logic [8:0] GRAY_LEN = 9'(INPUTS);

    logic              m_q;
    logic              px;
    logic [INPUTS:0]   gcat;

    assign px       = (bus.in_data >= THRESHOLD);
    assign gcat     = {s_q, px};
    // Mode only follows the pin on a frame's first byte; mid-frame changes are ignored.
    assign mode_eff = first ? bus.mode : m_q;
`else
    logic mode_unused;

    assign mode_unused = bus.mode;
    assign mode_eff    = 1'b0;
`endif

    always_comb begin
        s_d       = pcat[INPUTS-1:0];
        frame_len = PACKED_LEN;
`ifdef LGN_LOADER_GRAYSCALE_EN
        if (mode_eff) begin
            s_d       = gcat[INPUTS-1:0];
            frame_len = GRAY_LEN;
        end
`endif
        cnt_d    = (bus.in_start ? 9'd0 : cnt_q) + 9'd1;
        complete = (cnt_d == frame_len);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD;
            s_q     <= '0;
            o_q     <= '0;
            ov_q    <= 1'b0;
            cnt_q   <= '0;
            drop_q  <= '0;
`ifdef LGN_LOADER_GRAYSCALE_EN
            m_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                LOAD: begin
                    if (xfer) begin
                        ov_q <= 1'b0;
                    end
                    if (accept) begin
                        s_q <= s_d;
`ifdef LGN_LOADER_GRAYSCALE_EN
                        m_q <= mode_eff;
`endif
                        if (bus.in_start && (cnt_q != '0) && (drop_q != 8'hFF)) begin
                            drop_q <= drop_q + 8'd1;
                        end
                        if (complete) begin
                            cnt_q <= '0;
                            // A free (or simultaneously drained) O takes the frame directly.
                            if (o_free) begin
                                o_q  <= s_d;
                                ov_q <= 1'b1;
                            end else begin
                                state_q <= FULL;
                            end
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                end
                FULL: begin
                    if (xfer) begin
                        o_q     <= s_q;
                        cnt_q   <= '0;
                        state_q <= LOAD;
                    end
                end
                default: state_q <= LOAD;
            endcase
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_image  = o_q;
    assign bus.out_valid  = ov_q;
    assign bus.drop_count = drop_q;

endmodule
